hbridge_pwm_ctrl: RTL and testbench

//   Parametrised N-channel H-bridge motor driver controller. It replaces the

---
 rtl/hbridge_pwm_ctrl_if.sv | 30 +++
 rtl/hbridge_pwm_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hbridge_pwm_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hbridge_pwm_ctrl_if.sv
// Bus bundle for the H-bridge PWM controller: control inputs, sense inputs and bridge drive outputs.
interface hbridge_pwm_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int PWM_W  = 12,
  parameter int DEAD_W = 8
);
  logic [PWM_W-1:0]        period;
  logic [NUM_CH*PWM_W-1:0] duty;
  logic [NUM_CH-1:0]       dir;
  logic [NUM_CH-1:0]       brake;
  logic [NUM_CH-1:0]       en;
  logic [DEAD_W-1:0]       dead_cycles;
  logic [NUM_CH-1:0]       oc_in;
  logic [NUM_CH-1:0]       fault_clr;
  logic [NUM_CH-1:0]       in_a;
  logic [NUM_CH-1:0]       in_b;
  logic [NUM_CH-1:0]       en_out;
  logic [NUM_CH-1:0]       fault;
  logic                    pwm_sync;

  modport master (
    output period, duty, dir, brake, en, dead_cycles, oc_in, fault_clr,
    input  in_a, in_b, en_out, fault, pwm_sync
  );

  modport slave (
    input  period, duty, dir, brake, en, dead_cycles, oc_in, fault_clr,
    output in_a, in_b, en_out, fault, pwm_sync
  );
endinterface

// File: rtl/hbridge_pwm_ctrl.sv
// N-channel H-bridge controller: shared PWM timebase, per-channel direction/decay,
// reversal dead-time and filtered over-current trip. All pins are registered.
module hbridge_pwm_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int PWM_W    = 12,
  parameter int DEAD_W   = 8,
  parameter int FLT_FILT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  hbridge_pwm_ctrl_if.slave bus
);

  localparam int OC_W = $clog2(FLT_FILT + 1);
  localparam logic [OC_W-1:0] OC_SAT  = OC_W'(FLT_FILT);
  localparam logic [OC_W-1:0] OC_TRIP = OC_W'(FLT_FILT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD,
    S_FAULT
  } state_e;

  logic [PWM_W-1:0]                 cnt_q, cnt_d;
  logic [PWM_W-1:0]                 period_sh_q, period_sh_d;
  logic [NUM_CH-1:0][PWM_W-1:0]     duty_sh_q, duty_sh_d;
  logic [NUM_CH-1:0]                dir_sh_q, dir_sh_d;
  logic [NUM_CH-1:0]                brake_sh_q, brake_sh_d;
  logic                             wrap;

  state_e                           state_q [NUM_CH];
  state_e                           state_d [NUM_CH];
  logic [NUM_CH-1:0]                cur_dir_q, cur_dir_d;
  logic [NUM_CH-1:0][DEAD_W-1:0]    dead_cnt_q, dead_cnt_d;
  logic [NUM_CH-1:0][OC_W-1:0]      oc_cnt_q, oc_cnt_d;

  logic [NUM_CH-1:0]                in_a_q, in_a_d;
  logic [NUM_CH-1:0]                in_b_q, in_b_d;
  logic [NUM_CH-1:0]                en_out_q, en_out_d;
  logic [NUM_CH-1:0]                fault_q, fault_d;
  logic                             sync_q, sync_d;

  always_comb begin
    wrap        = (cnt_q == period_sh_q);
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    sync_d      = wrap;
    period_sh_d = wrap ? bus.period : period_sh_q;
    duty_sh_d   = wrap ? bus.duty   : duty_sh_q;
    dir_sh_d    = wrap ? bus.dir    : dir_sh_q;
    brake_sh_d  = wrap ? bus.brake  : brake_sh_q;
  end

  always_comb begin : p_chan
    logic trip;
    trip       = 1'b0;
    cur_dir_d  = cur_dir_q;
    dead_cnt_d = dead_cnt_q;
    oc_cnt_d   = oc_cnt_q;
    in_a_d     = '0;
    in_b_d     = '0;
    en_out_d   = '0;
    fault_d    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];

      if (!bus.oc_in[i]) begin
        oc_cnt_d[i] = '0;
      end else if (oc_cnt_q[i] != OC_SAT) begin
        oc_cnt_d[i] = oc_cnt_q[i] + 1'b1;
      end
      // Trip fires on the cycle the filter count reaches FLT_FILT.
      trip = bus.oc_in[i] && (oc_cnt_q[i] >= OC_TRIP);

      case (state_q[i])
        S_IDLE: begin
          if (wrap && bus.en[i]) begin
            state_d[i]   = S_RUN;
            cur_dir_d[i] = bus.dir[i];
          end
        end
        S_RUN: begin
          if (trip) begin
            state_d[i] = S_FAULT;
          end else if (!bus.en[i]) begin
            state_d[i] = S_IDLE;
          end else if (wrap && (bus.dir[i] != cur_dir_q[i])) begin
            if (bus.dead_cycles == '0) begin
              cur_dir_d[i] = bus.dir[i];
            end else begin
              state_d[i]    = S_DEAD;
              dead_cnt_d[i] = bus.dead_cycles;
            end
          end
        end
        S_DEAD: begin
          if (trip) begin
            state_d[i] = S_FAULT;
          end else if (!bus.en[i]) begin
            state_d[i] = S_IDLE;
          end else if (dead_cnt_q[i] == DEAD_W'(1)) begin
            state_d[i]   = S_RUN;
            cur_dir_d[i] = dir_sh_d[i];
          end else begin
            dead_cnt_d[i] = dead_cnt_q[i] - 1'b1;
          end
        end
        S_FAULT: begin
          if (bus.fault_clr[i] && !bus.oc_in[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase

      case (state_q[i])
        S_RUN: begin
          if (cnt_q < duty_sh_q[i]) begin
            en_out_d[i] = 1'b1;
            in_a_d[i]   = cur_dir_q[i];
            in_b_d[i]   = ~cur_dir_q[i];
          end else begin
            en_out_d[i] = brake_sh_q[i];
          end
        end
        S_FAULT: fault_d[i] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      dir_sh_q    <= '0;
      brake_sh_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
      end
      cur_dir_q   <= '0;
      dead_cnt_q  <= '0;
      oc_cnt_q    <= '0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      en_out_q    <= '0;
      fault_q     <= '0;
      sync_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      dir_sh_q    <= dir_sh_d;
      brake_sh_q  <= brake_sh_d;
      state_q     <= state_d;
      cur_dir_q   <= cur_dir_d;
      dead_cnt_q  <= dead_cnt_d;
      oc_cnt_q    <= oc_cnt_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      en_out_q    <= en_out_d;
      fault_q     <= fault_d;
      sync_q      <= sync_d;
    end
  end

  assign bus.in_a     = in_a_q;
  assign bus.in_b     = in_b_q;
  assign bus.en_out   = en_out_q;
  assign bus.fault    = fault_q;
  assign bus.pwm_sync = sync_q;

endmodule

// File: tb/tb_hbridge_pwm_ctrl.sv
// Self-checking bench for hbridge_pwm_ctrl: directed scenarios then random traffic,
// every cycle compared against a run-length/phase reference model.
module tb_hbridge_pwm_ctrl;
  localparam int NCH = 4;
  localparam int PW  = 12;
  localparam int DW  = 8;
  localparam int FF  = 4;

  localparam int M_OFF   = 0;
  localparam int M_DRIVE = 1;
  localparam int M_GAP   = 2;
  localparam int M_TRIP  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hbridge_pwm_ctrl_if #(.NUM_CH(NCH), .PWM_W(PW), .DEAD_W(DW)) bus ();

  hbridge_pwm_ctrl #(.NUM_CH(NCH), .PWM_W(PW), .DEAD_W(DW), .FLT_FILT(FF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_cnt, m_per;
  int m_duty [NCH];
  bit m_dir  [NCH];
  bit m_brk  [NCH];
  bit m_cdir [NCH];
  int m_mode [NCH];
  int m_gap  [NCH];
  int m_run  [NCH];
  logic [NCH-1:0] e_a, e_b, e_en, e_f;
  logic e_sync;

  task automatic model_reset();
    m_cnt = 0;
    m_per = 0;
    for (int c = 0; c < NCH; c++) begin
      m_duty[c] = 0; m_dir[c] = 0; m_brk[c] = 0; m_cdir[c] = 0;
      m_mode[c] = M_OFF; m_gap[c] = 0; m_run[c] = 0;
    end
  endtask

  // Pins after an edge reflect the model before that edge; then the model advances.
  task automatic model_edge();
    bit wrap;
    bit trip;
    wrap   = (m_cnt == m_per);
    e_sync = wrap;
    for (int c = 0; c < NCH; c++) begin
      e_a[c] = 0; e_b[c] = 0; e_en[c] = 0; e_f[c] = (m_mode[c] == M_TRIP);
      if (m_mode[c] == M_DRIVE) begin
        if (m_cnt < m_duty[c]) begin
          e_a[c] = m_cdir[c]; e_b[c] = !m_cdir[c]; e_en[c] = 1;
        end else begin
          e_en[c] = m_brk[c];
        end
      end
    end
    if (!rst_n) begin
      model_reset();
      e_a = '0; e_b = '0; e_en = '0; e_f = '0; e_sync = 0;
      return;
    end
    if (wrap) begin
      m_per = int'(bus.period);
      for (int c = 0; c < NCH; c++) begin
        m_duty[c] = int'(bus.duty[c*PW +: PW]);
        m_dir[c]  = bus.dir[c];
        m_brk[c]  = bus.brake[c];
      end
    end
    for (int c = 0; c < NCH; c++) begin
      trip = bus.oc_in[c] && (m_run[c] + 1 >= FF);
      case (m_mode[c])
        M_OFF: if (wrap && bus.en[c]) begin m_mode[c] = M_DRIVE; m_cdir[c] = m_dir[c]; end
        M_DRIVE: begin
          if (trip) m_mode[c] = M_TRIP;
          else if (!bus.en[c]) m_mode[c] = M_OFF;
          else if (wrap && m_dir[c] != m_cdir[c]) begin
            if (bus.dead_cycles == 0) m_cdir[c] = m_dir[c];
            else begin m_mode[c] = M_GAP; m_gap[c] = int'(bus.dead_cycles); end
          end
        end
        M_GAP: begin
          if (trip) m_mode[c] = M_TRIP;
          else if (!bus.en[c]) m_mode[c] = M_OFF;
          else begin
            m_gap[c]--;
            if (m_gap[c] == 0) begin m_mode[c] = M_DRIVE; m_cdir[c] = m_dir[c]; end
          end
        end
        default: if (bus.fault_clr[c] && !bus.oc_in[c]) m_mode[c] = M_OFF;
      endcase
      m_run[c] = bus.oc_in[c] ? m_run[c] + 1 : 0;
    end
    m_cnt = wrap ? 0 : m_cnt + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, {15'd0, bus.in_a, bus.in_b, bus.en_out, bus.fault, bus.pwm_sync},
        {15'd0, e_a, e_b, e_en, e_f, e_sync});
  endtask

  task automatic ticks(input string tag, input int n);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  task automatic wait_sync(input string tag);
    int n;
    n = 0;
    do begin
      tick(tag);
      n++;
    end while (bus.pwm_sync !== 1'b1 && n < 40);
    chk({tag, "_sync_seen"}, {31'd0, bus.pwm_sync}, 32'd1);
  endtask

  task automatic set_duty(input int c, input int v);
    bus.duty[c*PW +: PW] = PW'(v);
  endtask

  initial begin
    int ns, na, ne;
    model_reset();
    bus.period = 12'd9; bus.duty = '0; bus.dir = '0; bus.brake = '0; bus.en = '0;
    bus.dead_cycles = '0; bus.oc_in = '0; bus.fault_clr = '0;
    rst_n = 1'b0;
    ticks("reset", 3);
    chk("reset_pins", {15'd0, bus.in_a, bus.in_b, bus.en_out, bus.fault, bus.pwm_sync}, 32'd0);
    rst_n = 1'b1;

    // Scenario 1: 30% on, brake decay
    set_duty(0, 3); bus.dir[0] = 1; bus.brake[0] = 1; bus.en[0] = 1;
    ticks("t1_settle", 25);
    ns = 0; na = 0; ne = 0;
    for (int k = 0; k < 30; k++) begin
      tick("t1");
      ns += int'(bus.pwm_sync); na += int'(bus.in_a[0]); ne += int'(bus.en_out[0]);
    end
    chk("t1_sync_count", ns, 3);
    chk("t1_a_count", na, 9);
    chk("t1_en_count", ne, 30);

    // Scenario 2: duty above period, then zero duty mid-period
    bus.brake[0] = 0; set_duty(0, 12);
    ticks("t2_settle", 12);
    na = 0;
    for (int k = 0; k < 20; k++) begin tick("t2"); na += int'(bus.in_a[0]); end
    chk("t2_full_on", na, 20);
    ticks("t2_mid", 4);
    set_duty(0, 0);
    ticks("t2_zero", 25);
    chk("t2_zero_en", {31'd0, bus.en_out[0]}, 32'd0);

    // Scenario 3: reversal with and without dead-time
    set_duty(0, 3); bus.brake[0] = 1; bus.dead_cycles = 8'd5;
    wait_sync("t3_a"); ticks("t3_settle", 12);
    wait_sync("t3_b"); ticks("t3_mid", 3);
    bus.dir[0] = 0;
    ne = 0;
    for (int k = 0; k < 20; k++) begin tick("t3_dead"); ne += int'(!bus.en_out[0]); end
    chk("t3_gap_len", ne, 5);
    bus.dead_cycles = 8'd0;
    wait_sync("t3_c"); ticks("t3_mid0", 3);
    bus.dir[0] = 1;
    ne = 0;
    for (int k = 0; k < 20; k++) begin tick("t3_nodead"); ne += int'(!bus.en_out[0]); end
    chk("t3_no_gap", ne, 0);

    // Scenario 4: over-current filter, clear rules
    bus.oc_in[0] = 1; ticks("t4_short", 3);
    bus.oc_in[0] = 0; ticks("t4_short_lo", 2);
    chk("t4_no_trip", {31'd0, bus.fault[0]}, 32'd0);
    bus.oc_in[0] = 1; ticks("t4_long", 4);
    bus.oc_in[0] = 0; tick("t4_trip");
    chk("t4_tripped", {31'd0, bus.fault[0]}, 32'd1);
    bus.oc_in[0] = 1; bus.fault_clr[0] = 1; ticks("t4_clr_oc", 2);
    chk("t4_clr_ignored", {31'd0, bus.fault[0]}, 32'd1);
    bus.oc_in[0] = 0; tick("t4_clr");
    bus.fault_clr[0] = 0; tick("t4_idle");
    chk("t4_cleared", {31'd0, bus.fault[0]}, 32'd0);
    wait_sync("t4_rerun"); ticks("t4_run", 5);

    // Scenario 5: fault wins over enable fall on ch1
    bus.en[1] = 1; set_duty(1, 5); bus.dir[1] = 0;
    ticks("t5_settle", 12);
    bus.oc_in[1] = 1; ticks("t5_oc", 3);
    bus.en[1] = 0; tick("t5_same");
    bus.oc_in[1] = 0; tick("t5_after");
    chk("t5_fault1", {31'd0, bus.fault[1]}, 32'd1);
    chk("t5_fault0_clear", {31'd0, bus.fault[0]}, 32'd0);
    bus.fault_clr[1] = 1; tick("t5_clr"); bus.fault_clr[1] = 0;

    // Scenario 6: reset in the middle of a dead-time
    bus.dead_cycles = 8'd20;
    wait_sync("t6_a"); ticks("t6_mid", 2);
    bus.dir[0] = 0;
    wait_sync("t6_b"); ticks("t6_dead", 6);
    rst_n = 1'b0; tick("t6_rst");
    chk("t6_rst_pins", {15'd0, bus.in_a, bus.in_b, bus.en_out, bus.fault, bus.pwm_sync}, 32'd0);
    rst_n = 1'b1;
    ticks("t6_after", 15);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 9) < 2) bus.oc_in[c] = ~bus.oc_in[c];
        bus.fault_clr[c] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 29) == 0) bus.en[c] = ~bus.en[c];
        if ($urandom_range(0, 19) == 0) bus.dir[c] = ~bus.dir[c];
        if ($urandom_range(0, 19) == 0) bus.brake[c] = ~bus.brake[c];
        if ($urandom_range(0, 19) == 0) set_duty(c, int'($urandom_range(0, 17)));
      end
      if ($urandom_range(0, 39) == 0) bus.period = PW'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) bus.dead_cycles = DW'($urandom_range(0, 6));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
